// File: rtl/mastermind_round_sequencer.sv
// Mastermind round sequencer: button-driven slot strobes, a compare sweep and WIN/LOSS tracking.
// Optional BTN_DEBOUNCE_EN adds a stable-level debouncer between the synchronizer and the edge detector.
module mastermind_round_sequencer #(
    parameter int MAX_GUESSES     = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_btn,
    input  logic       new_game,
    input  logic [2:0] red_in,
    input  logic [2:0] white_in,
    output logic [3:0] load_code,
    output logic [3:0] load_guess,
    output logic       clear_score,
    output logic       compare_en,
    output logic [1:0] compare_i,
    output logic [3:0] guess_count,
    output logic [2:0] red_out,
    output logic [2:0] white_out,
    output logic       feedback_valid,
    output logic       won,
    output logic       lost
);
    typedef enum logic [3:0] {
        S_CODE, S_CODE_REL, S_GUESS, S_GUESS_REL,
        S_CLEAR, S_CMP, S_SETTLE, S_EVAL, S_WON, S_LOST
    } state_t;

    // Button flops reset high so a press held through reset never looks like a fresh rise.
    logic sync1_q, sync2_q, prev_q, btn_lvl, rise, fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= load_btn;
            sync2_q <= sync1_q;
            prev_q  <= btn_lvl;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          db_lvl_q, db_lvl_d;

    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_lvl_d = sync2_q;
            else                                      db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign rise = btn_lvl & ~prev_q;
    assign fall = ~btn_lvl & prev_q;

    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] load_code_q, load_code_d, load_guess_q, load_guess_d;
    logic [3:0] guess_count_q, guess_count_d, gc_inc;
    logic [2:0] red_q, red_d, white_q, white_d;
    logic       fb_q, fb_d, won_q, won_d, lost_q, lost_d, ng_clr_q, ng_clr_d;

    assign gc_inc = guess_count_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        load_code_d   = 4'b0000;
        load_guess_d  = 4'b0000;
        guess_count_d = guess_count_q;
        red_d         = red_q;
        white_d       = white_q;
        fb_d          = 1'b0;
        won_d         = won_q;
        lost_d        = lost_q;
        ng_clr_d      = 1'b0;
        if (new_game) begin
            state_d       = S_CODE;
            slot_d        = 2'd0;
            guess_count_d = 4'd0;
            red_d         = 3'd0;
            white_d       = 3'd0;
            won_d         = 1'b0;
            lost_d        = 1'b0;
            ng_clr_d      = 1'b1;
        end else begin
            case (state_q)
                S_CODE: if (rise) begin
                    load_code_d = 4'b0001 << slot_q;
                    state_d     = S_CODE_REL;
                end
                S_CODE_REL: if (fall) begin
                    state_d = (slot_q == 2'd3) ? S_GUESS : S_CODE;
                    slot_d  = slot_q + 2'd1;
                end
                S_GUESS: if (rise) begin
                    load_guess_d = 4'b0001 << slot_q;
                    state_d      = S_GUESS_REL;
                end
                S_GUESS_REL: if (fall) begin
                    state_d = (slot_q == 2'd3) ? S_CLEAR : S_GUESS;
                    slot_d  = slot_q + 2'd1;
                end
                S_CLEAR: begin
                    state_d = S_CMP;
                    slot_d  = 2'd0;
                end
                S_CMP: begin
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'd3) state_d = S_SETTLE;
                end
                S_SETTLE: state_d = S_EVAL;
                S_EVAL: begin
                    red_d   = red_in;
                    white_d = white_in;
                    fb_d    = 1'b1;
                    slot_d  = 2'd0;
                    if (red_in == 3'd4) begin
                        won_d   = 1'b1;
                        state_d = S_WON;
                    end else begin
                        guess_count_d = gc_inc;
                        if (gc_inc == 4'(MAX_GUESSES)) begin
                            lost_d  = 1'b1;
                            state_d = S_LOST;
                        end else begin
                            state_d = S_GUESS;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_CODE;
            slot_q        <= 2'd0;
            load_code_q   <= 4'b0000;
            load_guess_q  <= 4'b0000;
            guess_count_q <= 4'd0;
            red_q         <= 3'd0;
            white_q       <= 3'd0;
            fb_q          <= 1'b0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
            ng_clr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            load_code_q   <= load_code_d;
            load_guess_q  <= load_guess_d;
            guess_count_q <= guess_count_d;
            red_q         <= red_d;
            white_q       <= white_d;
            fb_q          <= fb_d;
            won_q         <= won_d;
            lost_q        <= lost_d;
            ng_clr_q      <= ng_clr_d;
        end
    end

    assign load_code      = load_code_q;
    assign load_guess     = load_guess_q;
    assign clear_score    = (state_q == S_CLEAR) | ng_clr_q;
    assign compare_en     = (state_q == S_CMP);
    assign compare_i      = (state_q == S_CMP) ? slot_q : 2'd0;
    assign guess_count    = guess_count_q;
    assign red_out        = red_q;
    assign white_out      = white_q;
    assign feedback_valid = fb_q;
    assign won            = won_q;
    assign lost           = lost_q;
endmodule

// File: tb/tb_mastermind_round_sequencer.sv
// Directed bench for mastermind_round_sequencer (MAX_GUESSES=2); debounce checks when BTN_DEBOUNCE_EN is defined.
module tb_mastermind_round_sequencer;
    logic       clk = 1'b0, resetn = 1'b0, load_btn = 1'b0, new_game = 1'b0;
    logic [2:0] red_in = 3'd0, white_in = 3'd0;
    logic [3:0] load_code, load_guess, guess_count;
    logic       clear_score, compare_en, feedback_valid, won, lost;
    logic [1:0] compare_i;
    logic [2:0] red_out, white_out;

`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif

    int checks = 0;
    int errors = 0;

    mastermind_round_sequencer #(.MAX_GUESSES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn), .load_btn(load_btn), .new_game(new_game),
        .red_in(red_in), .white_in(white_in),
        .load_code(load_code), .load_guess(load_guess), .clear_score(clear_score),
        .compare_en(compare_en), .compare_i(compare_i), .guess_count(guess_count),
        .red_out(red_out), .white_out(white_out), .feedback_valid(feedback_valid),
        .won(won), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Press and hold; capture the strobes at edge LAT, count strobes at any other edge.
    task automatic press_obs(output logic [3:0] lc, output logic [3:0] lg, output int stray);
        stray = 0; lc = 4'b0; lg = 4'b0;
        load_btn = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            if (e == LAT) begin lc = load_code; lg = load_guess; end
            else stray += int'(|{load_code, load_guess});
        end
    endtask

    task automatic release_obs(output int stray);
        stray = 0;
        load_btn = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            step();
            stray += int'(|{load_code, load_guess});
        end
    endtask

    task automatic do_code();
        logic [3:0] lc, lg;
        int s;
        for (int k = 0; k < 4; k++) begin
            press_obs(lc, lg, s);
            release_obs(s);
        end
    endtask

    // Enter four guess pegs; returns in the CLEAR cycle with the release-to-clear edge count.
    task automatic enter_guess(output logic [3:0] first_lg, output int lat_clr);
        logic [3:0] lc, lg;
        int s;
        first_lg = 4'b0;
        for (int k = 0; k < 4; k++) begin
            press_obs(lc, lg, s);
            if (k == 0) first_lg = lg;
            if (k < 3) release_obs(s);
        end
        load_btn = 1'b0;
        lat_clr = -1;
        for (int e = 1; e <= 40 && lat_clr < 0; e++) begin
            step();
            if (clear_score) lat_clr = e;
        end
    endtask

    task automatic wait_fb(output int n);
        n = -1;
        for (int e = 1; e <= 20 && n < 0; e++) begin
            step();
            if (feedback_valid) n = e;
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] all_out;
        resetn = 1'b0; load_btn = 1'b0;
        repeat (3) step();
        all_out = {load_code, load_guess, clear_score, compare_en, compare_i, guess_count,
                   red_out, white_out, feedback_valid, won, lost};
        checks++;
        if (all_out !== 28'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
        resetn = 1'b1;
        repeat (2) step();
        all_out = {load_code, load_guess, clear_score, compare_en, compare_i, guess_count,
                   red_out, white_out, feedback_valid, won, lost};
        checks++;
        if (all_out !== 28'd0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", all_out); end
    endtask

    task automatic test_code_load();
        logic [3:0] lc, lg, exp;
        int s, r;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            press_obs(lc, lg, s);
            release_obs(r);
            checks++;
            if (lc !== exp || lg !== 4'b0 || s != 0 || r != 0) begin
                errors++;
                $display("FAIL code_strobe%0d got lc=%b lg=%b stray=%0d/%0d exp lc=%b lg=0000 stray=0", k, lc, lg, s, r, exp);
            end
        end
    endtask

    task automatic test_win();
        logic [3:0] flg, lc, lg;
        int lat, s;
        red_in = 3'd4; white_in = 3'd0;
        enter_guess(flg, lat);
        checks++;
        if (flg !== 4'b0001) begin errors++; $display("FAIL win_first_guess got %b exp 0001", flg); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL win_clear_latency got %0d exp %0d", lat, LAT); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (compare_en !== 1'b1 || compare_i !== 2'(i) || clear_score !== 1'b0) begin
                errors++;
                $display("FAIL win_cmp%0d got en=%b i=%0d clr=%b exp en=1 i=%0d clr=0", i, compare_en, compare_i, clear_score, i);
            end
        end
        step();
        checks++;
        if (compare_en !== 1'b0 || feedback_valid !== 1'b0) begin
            errors++; $display("FAIL win_settle got en=%b fb=%b exp 0 0", compare_en, feedback_valid);
        end
        step();
        step();
        checks++;
        if (feedback_valid !== 1'b1 || red_out !== 3'd4 || won !== 1'b1 || lost !== 1'b0 || guess_count !== 4'd0) begin
            errors++;
            $display("FAIL win_feedback got fb=%b red=%0d won=%b lost=%b gc=%0d exp 1 4 1 0 0", feedback_valid, red_out, won, lost, guess_count);
        end
        step();
        checks++;
        if (feedback_valid !== 1'b0 || won !== 1'b1) begin
            errors++; $display("FAIL win_hold got fb=%b won=%b exp 0 1", feedback_valid, won);
        end
        press_obs(lc, lg, s);
        release_obs(s);
        checks++;
        if (lc !== 4'b0 || lg !== 4'b0 || s != 0 || won !== 1'b1) begin
            errors++; $display("FAIL win_ignore_btn got lc=%b lg=%b stray=%0d won=%b exp 0000 0000 0 1", lc, lg, s, won);
        end
    endtask

    task automatic test_lose();
        logic [3:0] flg, lc, lg;
        int lat, n, s;
        pulse_new_game();
        checks++;
        if (clear_score !== 1'b1 || won !== 1'b0 || red_out !== 3'd0) begin
            errors++; $display("FAIL ng_after_win got clr=%b won=%b red=%0d exp 1 0 0", clear_score, won, red_out);
        end
        step();
        checks++;
        if (clear_score !== 1'b0) begin errors++; $display("FAIL ng_clear_width got %b exp 0", clear_score); end
        do_code();
        red_in = 3'd1; white_in = 3'd2;
        enter_guess(flg, lat);
        wait_fb(n);
        checks++;
        if (n != 7 || guess_count !== 4'd1 || red_out !== 3'd1 || white_out !== 3'd2 || lost !== 1'b0) begin
            errors++;
            $display("FAIL lose_guess1 got fbdly=%0d gc=%0d red=%0d white=%0d lost=%b exp 7 1 1 2 0", n, guess_count, red_out, white_out, lost);
        end
        enter_guess(flg, lat);
        checks++;
        if (flg !== 4'b0001) begin errors++; $display("FAIL lose_regress_guess0 got %b exp 0001", flg); end
        wait_fb(n);
        checks++;
        if (n < 0 || guess_count !== 4'd2 || lost !== 1'b1 || won !== 1'b0) begin
            errors++; $display("FAIL lose_guess2 got fbdly=%0d gc=%0d lost=%b won=%b exp gc=2 lost=1 won=0", n, guess_count, lost, won);
        end
        press_obs(lc, lg, s);
        release_obs(s);
        checks++;
        if (lc !== 4'b0 || lg !== 4'b0 || s != 0 || guess_count !== 4'd2 || lost !== 1'b1) begin
            errors++; $display("FAIL lost_frozen got lc=%b lg=%b stray=%0d gc=%0d lost=%b", lc, lg, s, guess_count, lost);
        end
    endtask

    task automatic test_new_game_mid_cmp();
        logic [3:0] flg, lc, lg;
        int lat, n, s, en_cnt, st_cnt, clr_cnt;
        pulse_new_game();
        checks++;
        if (guess_count !== 4'd0 || lost !== 1'b0) begin
            errors++; $display("FAIL ng_after_lost got gc=%0d lost=%b exp 0 0", guess_count, lost);
        end
        step();
        do_code();
        red_in = 3'd1; white_in = 3'd2;
        enter_guess(flg, lat);
        wait_fb(n);
        enter_guess(flg, lat);
`ifndef BTN_DEBOUNCE_EN
        load_btn = 1'b1;
`endif
        step();
        step();
        checks++;
        if (compare_en !== 1'b1 || compare_i !== 2'd1 || guess_count !== 4'd1) begin
            errors++; $display("FAIL mid_cmp_setup got en=%b i=%0d gc=%0d exp 1 1 1", compare_en, compare_i, guess_count);
        end
        pulse_new_game();
        checks++;
        if (compare_en !== 1'b0 || clear_score !== 1'b1 || guess_count !== 4'd0 || red_out !== 3'd0 ||
            white_out !== 3'd0 || |{load_code, load_guess}) begin
            errors++;
            $display("FAIL ng_mid_cmp got en=%b clr=%b gc=%0d red=%0d white=%0d lc=%b lg=%b", compare_en, clear_score, guess_count, red_out, white_out, load_code, load_guess);
        end
        en_cnt = 0; st_cnt = 0; clr_cnt = 0;
        for (int e = 0; e < 8; e++) begin
            step();
            en_cnt += int'(compare_en);
            st_cnt += int'(|{load_code, load_guess});
            clr_cnt += int'(clear_score);
        end
        checks++;
        if (en_cnt != 0 || st_cnt != 0 || clr_cnt != 0) begin
            errors++; $display("FAIL ng_aftermath got en=%0d strobes=%0d clr=%0d exp 0 0 0", en_cnt, st_cnt, clr_cnt);
        end
        release_obs(s);
        press_obs(lc, lg, s);
        release_obs(n);
        checks++;
        if (lc !== 4'b0001 || lg !== 4'b0 || s != 0 || n != 0) begin
            errors++; $display("FAIL ng_code0 got lc=%b lg=%b stray=%0d/%0d exp 0001 0000 0", lc, lg, s, n);
        end
    endtask

    task automatic test_held_reset();
        logic [3:0] lc, lg;
        int s, cnt;
        resetn = 1'b0; load_btn = 1'b1;
        repeat (3) step();
        resetn = 1'b1;
        cnt = 0;
        for (int e = 0; e < LAT + 8; e++) begin
            step();
            cnt += int'(|{load_code, load_guess});
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL held_reset_no_strobe got %0d exp 0", cnt); end
        release_obs(s);
        press_obs(lc, lg, s);
        checks++;
        if (lc !== 4'b0001 || s != 0) begin
            errors++; $display("FAIL held_reset_repress got lc=%b stray=%0d exp 0001 0", lc, s);
        end
        release_obs(s);
    endtask

`ifdef BTN_DEBOUNCE_EN
    task automatic test_debounce();
        int cnt, first;
        load_btn = 1'b1;
        repeat (10) step();
        load_btn = 1'b0;
        cnt = 0;
        for (int e = 0; e < 30; e++) begin
            step();
            cnt += int'(|{load_code, load_guess});
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL debounce_glitch got %0d strobes exp 0", cnt); end
        load_btn = 1'b1;
        first = -1; cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (|{load_code, load_guess}) begin
                cnt++;
                if (first < 0) first = e;
            end
        end
        load_btn = 1'b0;
        repeat (20) step();
        checks++;
        if (first != 19 || cnt != 1) begin
            errors++; $display("FAIL debounce_latency got edge=%0d count=%0d exp 19 1", first, cnt);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_code_load();
        test_win();
        test_lose();
        test_new_game_mid_cmp();
        test_held_reset();
`ifdef BTN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
